// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - FSM state type and counter sizing for result_serializer
// RESULT_SERIALIZER_PARITY_EN adds the PARITY state.
package result_serializer_pkg;

`ifdef RESULT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

  function automatic int cnt_width(input int num_dst);
    return $clog2(num_dst + 1);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - captures a parallel compressor result and shifts it out under valid/ready
// RESULT_SERIALIZER_PARITY_EN appends an even-parity bit after the data bits.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int NUM_DST   = 17,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DST-1:0] dst,
  input  logic               start,
  output logic               sout,
  output logic               sout_valid,
  input  logic               sout_ready,
  output logic               busy,
  output logic               done
);

  localparam int            CW   = cnt_width(NUM_DST);
  localparam logic [CW-1:0] LAST = CW'(NUM_DST - 1);

  state_t             state;
  logic [NUM_DST-1:0] shreg;
  logic [NUM_DST-1:0] shreg_next;
  logic [CW-1:0]      cnt;
  logic               xfer;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic               parity;
`endif

  // The bit on the wire is always the head of the shift register.
  function automatic logic head(input logic [NUM_DST-1:0] v);
    return LSB_FIRST ? v[0] : v[NUM_DST-1];
  endfunction

  assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  assign xfer       = sout_valid & sout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SHIFT;
            shreg      <= dst;
            cnt        <= '0;
            sout       <= head(dst);
            sout_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef RESULT_SERIALIZER_PARITY_EN
            parity     <= ^dst;
`endif
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            // Counter saturates on the last data bit; it is reloaded on the next capture.
            if (cnt == LAST) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
              state      <= ST_PARITY;
              sout       <= parity;
`else
              state      <= ST_IDLE;
              sout       <= 1'b0;
              sout_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
`endif
            end else begin
              shreg <= shreg_next;
              sout  <= head(shreg_next);
              cnt   <= cnt + 1'b1;
            end
          end
        end
`ifdef RESULT_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (xfer) begin
            state      <= ST_IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - self-checking bench for result_serializer
// Parity frames are expected when RESULT_SERIALIZER_PARITY_EN is defined.
module tb_result_serializer;

  localparam int N   = 17;
  localparam bit LSB = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] dst;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];

  typedef struct {
    logic [N-1:0] dst;
    int           stall_at;
    int           stall_len;
    int           repulse_at;
    logic [N-1:0] exp_frame;
    bit           exp_par;
  } vec_t;

  vec_t tbl[6];

  result_serializer #(.NUM_DST(N), .LSB_FIRST(LSB)) dut (
    .clk        (clk),
    .rst        (rst),
    .dst        (dst),
    .start      (start),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: frame = data bits in wire order, then popcount parity when enabled.
  function automatic void model_frame(input logic [N-1:0] d);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(LSB ? d[i] : d[N-1-i]);
`ifdef RESULT_SERIALIZER_PARITY_EN
    begin
      int ones = 0;
      for (int i = 0; i < N; i++) ones += int'(d[i]);
      exp_q.push_back(bit'(ones % 2));
    end
`endif
  endfunction

  function automatic void table_frame(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(v.exp_frame[i]);
`ifdef RESULT_SERIALIZER_PARITY_EN
    exp_q.push_back(v.exp_par);
`endif
  endfunction

  task automatic launch(input logic [N-1:0] d, input bit hold);
    dst   = d;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    dst = N'($urandom);
  endtask

  // Called at the negedge where the first bit should be on the wire.
  task automatic collect(input string tag, input int stall_at, input int stall_len,
                         input int repulse_at, input bit rnd, input int abort_at,
                         input bit hold_start);
    int idx    = 0;
    int stalls = 0;
    int cycles = 0;
    bit rdy;
    while (idx < exp_q.size() && idx != abort_at) begin
      if (cycles >= 400) begin
        check($sformatf("%s_timeout", tag), idx, exp_q.size());
        break;
      end
      check($sformatf("%s_bit%0d", tag, idx), {sout_valid, sout, busy, done},
            {1'b1, exp_q[idx], 1'b1, 1'b0});
      rdy = 1'b1;
      if (idx == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      sout_ready = rdy;
      if (idx == repulse_at && rdy) begin
        start = 1'b1;
        dst   = '0;
      end else if (!hold_start) begin
        start = 1'b0;
      end
      if (rdy) idx++;
      cycles++;
      @(negedge clk);
    end
    sout_ready = 1'b1;
    if (!hold_start) start = 1'b0;
    if (abort_at < 0)
      check($sformatf("%s_done", tag), {done, busy, sout_valid, sout}, 4'b1000);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dst        = '0;
    sout_ready = 1'b1;
    #1;
    check("reset_outputs", {sout, sout_valid, busy, done}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {sout, sout_valid, busy, done}, 4'b0000);

    tbl[0] = '{17'h12345, -1, 0, -1, 17'h12345, 1'b1};
    tbl[1] = '{17'h12345,  5, 3, -1, 17'h12345, 1'b1};
    tbl[2] = '{17'h12345, -1, 0,  8, 17'h12345, 1'b1};
    tbl[3] = '{17'h1FFFF, 16, 2, -1, 17'h1FFFF, 1'b1};
    tbl[4] = '{17'h00000,  0, 4, -1, 17'h00000, 1'b0};
    tbl[5] = '{17'h10001, -1, 0, -1, 17'h10001, 1'b0};

    for (int t = 0; t < 6; t++) begin
      table_frame(tbl[t]);
      launch(tbl[t].dst, 1'b0);
      collect($sformatf("tbl%0d", t), tbl[t].stall_at, tbl[t].stall_len,
              tbl[t].repulse_at, 1'b0, -1, 1'b0);
      @(negedge clk);
      check($sformatf("tbl%0d_single_done", t), {done, busy, sout_valid}, 3'b000);
    end

    // start held high across done: second frame follows with one-cycle gap
    model_frame(17'h0ABCD);
    launch(17'h0ABCD, 1'b1);
    collect("b2b_first", -1, 0, -1, 1'b0, -1, 1'b1);
    dst = 17'h1C3A5;
    @(negedge clk);
    start = 1'b0;
    model_frame(17'h1C3A5);
    collect("b2b_second", -1, 0, -1, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("b2b_idle", {done, busy, sout_valid}, 3'b000);

    // reset mid-frame at bit 10
    model_frame(17'h12345);
    launch(17'h12345, 1'b0);
    collect("abort", -1, 0, -1, 1'b0, 10, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {sout, sout_valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("no_done_after_abort%0d", c), {done, busy, sout_valid, sout}, 4'b0000);
    end
    model_frame(17'h12345);
    launch(17'h12345, 1'b0);
    collect("after_rst", -1, 0, -1, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("after_rst_idle", {done, busy, sout_valid}, 3'b000);

    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] d;
      d = N'($urandom);
      model_frame(d);
      launch(d, 1'b0);
      collect($sformatf("rand%0d", r), -1, 0, -1, 1'b1, -1, 1'b0);
      @(negedge clk);
      check($sformatf("rand%0d_idle", r), {done, busy, sout_valid}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
